// File: rtl/magnitude.sv
// Pipelined unsigned vector magnitude, data_out = sqrt(data_in_1^2 + data_in_2^2).
// Build option MAGNITUDE_ROUND_EN: round the root to nearest (saturating) instead of truncating.
module magnitude #(
   parameter int SQUARE_ROOT_BITS = 13,
   parameter int DATA_IN_BITS     = 16,
   localparam int SQUARE_SUM_OUT_BITS = 2 * DATA_IN_BITS + 1,
   localparam int DATA_OUT_BITS       = DATA_IN_BITS + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     data_in_ready,
   input  logic [DATA_IN_BITS-1:0]  data_in_1,
   input  logic [DATA_IN_BITS-1:0]  data_in_2,
   output logic                     data_out_ready,
   output logic [DATA_OUT_BITS-1:0] data_out
);

   localparam int W         = 2 * SQUARE_ROOT_BITS;
   localparam int N         = SQUARE_ROOT_BITS;
   localparam int REM_BITS  = N + 3;
   localparam int MAX_HALF  = (SQUARE_SUM_OUT_BITS > W) ? (SQUARE_SUM_OUT_BITS - W + 1) / 2 : 0;
   localparam int HALF_BITS = (MAX_HALF > 0) ? $clog2(MAX_HALF + 1) : 1;

   logic [SQUARE_SUM_OUT_BITS-1:0] square_sum_out;
   logic                           square_sum_out_ready;
   logic [SQUARE_SUM_OUT_BITS-1:0] squareSum_d;

   // Index 0 holds the normalized operand; index j holds the state after j root iterations.
   logic [W-1:0]         operand_q    [N];
   logic [W-1:0]         operand_d    [N];
   logic [REM_BITS-1:0]  remainder_q  [N];
   logic [REM_BITS-1:0]  remainder_d  [N];
   logic [N-1:0]         partRoot_q   [N];
   logic [N-1:0]         partRoot_d   [N];
   logic [HALF_BITS-1:0] halfShift_q  [N];
   logic [HALF_BITS-1:0] halfShift_d  [N];
   logic                 stageValid_q [N];
   logic                 stageValid_d [N];

   logic [REM_BITS-1:0]      lastRemShift;
   logic [REM_BITS-1:0]      lastTrial;
   logic [N-1:0]             rootFloor;
   logic [N-1:0]             rootOut;
   logic [DATA_OUT_BITS-1:0] dataOut_q;
   logic [DATA_OUT_BITS-1:0] dataOut_d;
   logic                     dataOutReady_q;
`ifdef MAGNITUDE_ROUND_EN
   logic [REM_BITS-1:0]      lastRem;
`endif

   always_comb begin
      squareSum_d = SQUARE_SUM_OUT_BITS'(data_in_1) * SQUARE_SUM_OUT_BITS'(data_in_1)
                  + SQUARE_SUM_OUT_BITS'(data_in_2) * SQUARE_SUM_OUT_BITS'(data_in_2);
   end

   // Normalize by the smallest even shift that fits the root core, then one root bit per stage.
   always_comb begin
      logic [SQUARE_SUM_OUT_BITS-1:0] shifted;
      logic [REM_BITS-1:0]            remShift;
      logic [REM_BITS-1:0]            trial;
      shifted         = '0;
      remShift        = '0;
      trial           = '0;
      operand_d[0]    = '0;
      halfShift_d[0]  = '0;
      remainder_d[0]  = '0;
      partRoot_d[0]   = '0;
      stageValid_d[0] = square_sum_out_ready;
      for (int h = MAX_HALF; h >= 0; h--) begin
         shifted = square_sum_out >> (2 * h);
         if ((shifted >> W) == '0) begin
            operand_d[0]   = W'(shifted);
            halfShift_d[0] = HALF_BITS'(h);
         end
      end
      for (int j = 1; j < N; j++) begin
         remShift        = REM_BITS'({remainder_q[j-1], operand_q[j-1][W-1 -: 2]});
         trial           = REM_BITS'({partRoot_q[j-1], 2'b01});
         operand_d[j]    = operand_q[j-1] << 2;
         halfShift_d[j]  = halfShift_q[j-1];
         stageValid_d[j] = stageValid_q[j-1];
         if (remShift >= trial) begin
            remainder_d[j] = remShift - trial;
            partRoot_d[j]  = N'({partRoot_q[j-1], 1'b1});
         end else begin
            remainder_d[j] = remShift;
            partRoot_d[j]  = N'({partRoot_q[j-1], 1'b0});
         end
      end
   end

   // The last root iteration feeds the output register directly, together with the denormalizing shift.
   always_comb begin
      lastRemShift = REM_BITS'({remainder_q[N-1], operand_q[N-1][W-1 -: 2]});
      lastTrial    = REM_BITS'({partRoot_q[N-1], 2'b01});
      rootFloor    = N'({partRoot_q[N-1], (lastRemShift >= lastTrial)});
`ifdef MAGNITUDE_ROUND_EN
      lastRem = (lastRemShift >= lastTrial) ? (lastRemShift - lastTrial) : lastRemShift;
      rootOut = rootFloor;
      if ((lastRem > REM_BITS'(rootFloor)) && (rootFloor != '1)) begin
         rootOut = rootFloor + 1'b1;
      end
`else
      rootOut = rootFloor;
`endif
      dataOut_d = dataOut_q;
      if (stageValid_q[N-1]) begin
         dataOut_d = DATA_OUT_BITS'(rootOut) << halfShift_q[N-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         square_sum_out       <= '0;
         square_sum_out_ready <= 1'b0;
         for (int j = 0; j < N; j++) begin
            operand_q[j]    <= '0;
            remainder_q[j]  <= '0;
            partRoot_q[j]   <= '0;
            halfShift_q[j]  <= '0;
            stageValid_q[j] <= 1'b0;
         end
         dataOut_q      <= '0;
         dataOutReady_q <= 1'b0;
      end else begin
         square_sum_out_ready <= data_in_ready;
         if (data_in_ready) begin
            square_sum_out <= squareSum_d;
         end
         for (int j = 0; j < N; j++) begin
            operand_q[j]    <= operand_d[j];
            remainder_q[j]  <= remainder_d[j];
            partRoot_q[j]   <= partRoot_d[j];
            halfShift_q[j]  <= halfShift_d[j];
            stageValid_q[j] <= stageValid_d[j];
         end
         dataOut_q      <= dataOut_d;
         dataOutReady_q <= stageValid_q[N-1];
      end
   end

   assign data_out       = dataOut_q;
   assign data_out_ready = dataOutReady_q;

endmodule

// File: tb/tb_magnitude.sv
// Self-checking bench for magnitude: stimulus tables replayed cycle by cycle, outputs compared
// against an arithmetic model of the square-sum / normalize / root / shift rule.
module tb_magnitude;

   localparam int SQRT_BITS = 13;
   localparam int IN_BITS   = 16;
   localparam int OUT_BITS  = IN_BITS + 1;
   localparam int SS_BITS   = 2 * IN_BITS + 1;
   localparam int LAT_OUT   = SQRT_BITS + 2;
   localparam int MAXC      = 400;

   logic                clk = 1'b0;
   logic                rst;
   logic                data_in_ready;
   logic [IN_BITS-1:0]  data_in_1;
   logic [IN_BITS-1:0]  data_in_2;
   logic                data_out_ready;
   logic [OUT_BITS-1:0] data_out;

   int testsRun    = 0;
   int testsFailed = 0;

   // Row c is driven for rising edge c; obs[c] is what the DUT shows just before edge c.
   logic               tabRst   [MAXC];
   logic               tabValid [MAXC];
   logic [IN_BITS-1:0] tabA     [MAXC];
   logic [IN_BITS-1:0] tabB     [MAXC];
   logic                obsReady   [MAXC];
   logic [OUT_BITS-1:0] obsOut     [MAXC];
   logic                obsSsReady [MAXC];
   logic [SS_BITS-1:0]  obsSs      [MAXC];

   always #5 clk = ~clk;

   magnitude #(
      .SQUARE_ROOT_BITS(SQRT_BITS),
      .DATA_IN_BITS(IN_BITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .data_in_ready(data_in_ready),
      .data_in_1(data_in_1),
      .data_in_2(data_in_2),
      .data_out_ready(data_out_ready),
      .data_out(data_out)
   );

   function automatic longint unsigned sqModel(input logic [IN_BITS-1:0] a, input logic [IN_BITS-1:0] b);
      longint unsigned x;
      longint unsigned y;
      x = a;
      y = b;
      return x * x + y * y;
   endfunction

   function automatic longint unsigned magModel(input logic [IN_BITS-1:0] a, input logic [IN_BITS-1:0] b);
      longint unsigned s;
      longint unsigned limit;
      longint unsigned sp;
      longint unsigned r;
      int k;
      s     = sqModel(a, b);
      limit = 64'd1 << (2 * SQRT_BITS);
      k     = 0;
      while ((s >> k) >= limit) k += 2;
      sp = s >> k;
      r  = longint'($floor($sqrt(real'(sp))));
      while (r * r > sp) r--;
      while ((r + 1) * (r + 1) <= sp) r++;
`ifdef MAGNITUDE_ROUND_EN
      if (((sp - r * r) > r) && (r < ((64'd1 << SQRT_BITS) - 1))) r++;
`endif
      return r << (k / 2);
   endfunction

   task automatic applyStimulus(input int n, input int total);
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         obsReady[c]   = data_out_ready;
         obsOut[c]     = data_out;
         obsSsReady[c] = dut.square_sum_out_ready;
         obsSs[c]      = dut.square_sum_out;
         if (c < n) begin
            rst           = tabRst[c];
            data_in_ready = tabValid[c];
            data_in_1     = tabA[c];
            data_in_2     = tabB[c];
         end else begin
            rst           = 1'b1;
            data_in_ready = 1'b0;
            data_in_1     = IN_BITS'($urandom);
            data_in_2     = IN_BITS'($urandom);
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         tabRst[i]   = 1'b0;
         tabValid[i] = 1'b1;
         tabA[i]     = IN_BITS'($urandom);
         tabB[i]     = ~tabA[i];
      end
      applyStimulus(3, 20);
      for (int c = 1; c < 20; c++) begin
         testsRun++;
         if (obsReady[c] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_out_ready c=%0d got %b expected 0", c, obsReady[c]);
         end
         testsRun++;
         if (obsSsReady[c] !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_ss_ready c=%0d got %b expected 0", c, obsSsReady[c]);
         end
         testsRun++;
         if (obsOut[c] !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data_out c=%0d got %0d expected 0", c, obsOut[c]);
         end
         if (c <= 3) begin
            testsRun++;
            if (obsSs[c] !== '0) begin
               testsFailed++;
               $display("[TB] FAIL reset_square_sum c=%0d got %0d expected 0", c, obsSs[c]);
            end
         end
      end
   endtask

   task automatic test_single();
      tabRst[0] = 1'b1; tabValid[0] = 1'b1; tabA[0] = 16'd3; tabB[0] = 16'd4;
      applyStimulus(1, 20);
      for (int c = 0; c < 20; c++) begin
         testsRun++;
         if (obsReady[c] !== (c == LAT_OUT)) begin
            testsFailed++;
            $display("[TB] FAIL single_out_ready c=%0d got %b expected %b", c, obsReady[c], (c == LAT_OUT));
         end
         testsRun++;
         if (obsSsReady[c] !== (c == 1)) begin
            testsFailed++;
            $display("[TB] FAIL single_ss_ready c=%0d got %b expected %b", c, obsSsReady[c], (c == 1));
         end
         if (c >= LAT_OUT) begin
            testsRun++;
            if (obsOut[c] !== 17'd5) begin
               testsFailed++;
               $display("[TB] FAIL single_data_out c=%0d got %0d expected 5", c, obsOut[c]);
            end
         end
      end
      testsRun++;
      if (obsSs[1] !== 33'd25) begin
         testsFailed++;
         $display("[TB] FAIL single_square_sum got %0d expected 25", obsSs[1]);
      end
   endtask

   task automatic test_back_to_back();
      longint unsigned expSs [4];
      longint unsigned expOut [4];
      expSs  = '{64'd0, 64'd16777216, 64'd67108864, 64'd8589672450};
`ifdef MAGNITUDE_ROUND_EN
      expOut = '{64'd0, 64'd4096, 64'd8192, 64'd92688};
`else
      expOut = '{64'd0, 64'd4096, 64'd8192, 64'd92672};
`endif
      tabA[0] = 16'd0;     tabB[0] = 16'd0;
      tabA[1] = 16'd4096;  tabB[1] = 16'd0;
      tabA[2] = 16'd8192;  tabB[2] = 16'd0;
      tabA[3] = 16'd65535; tabB[3] = 16'd65535;
      for (int i = 0; i < 4; i++) begin
         tabRst[i]   = 1'b1;
         tabValid[i] = 1'b1;
      end
      applyStimulus(4, 22);
      for (int c = 0; c < 22; c++) begin
         testsRun++;
         if (obsReady[c] !== ((c >= LAT_OUT) && (c < LAT_OUT + 4))) begin
            testsFailed++;
            $display("[TB] FAIL stream_out_ready c=%0d got %b", c, obsReady[c]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         testsRun++;
         if (obsSs[1 + i] !== SS_BITS'(expSs[i])) begin
            testsFailed++;
            $display("[TB] FAIL stream_square_sum i=%0d got %0d expected %0d", i, obsSs[1 + i], expSs[i]);
         end
         testsRun++;
         if (obsOut[LAT_OUT + i] !== OUT_BITS'(expOut[i])) begin
            testsFailed++;
            $display("[TB] FAIL stream_data_out i=%0d got %0d expected %0d", i, obsOut[LAT_OUT + i], expOut[i]);
         end
      end
   endtask

   task automatic test_random();
      int n;
      int total;
      int outCount;
      logic haveOut;
      longint unsigned lastOut;
      n = 300;
      total = n + LAT_OUT + 2;
      for (int i = 0; i < n; i++) begin
         tabRst[i]   = 1'b1;
         tabValid[i] = 1'b1;
         tabA[i]     = IN_BITS'($urandom_range(0, 65535) >> $urandom_range(0, 15));
         tabB[i]     = IN_BITS'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      end
      applyStimulus(n, total);
      outCount = 0;
      haveOut  = 1'b0;
      lastOut  = 0;
      for (int c = 0; c < total; c++) begin
         int si;
         int oi;
         logic expSsR;
         logic expR;
         si = c - 1;
         oi = c - LAT_OUT;
         expSsR = ((si >= 0) && (si < n)) ? tabValid[si] : 1'b0;
         expR   = ((oi >= 0) && (oi < n)) ? tabValid[oi] : 1'b0;
         testsRun++;
         if (obsSsReady[c] !== expSsR) begin
            testsFailed++;
            $display("[TB] FAIL random_ss_ready c=%0d got %b expected %b", c, obsSsReady[c], expSsR);
         end
         if (expSsR) begin
            testsRun++;
            if (obsSs[c] !== SS_BITS'(sqModel(tabA[si], tabB[si]))) begin
               testsFailed++;
               $display("[TB] FAIL random_square_sum c=%0d got %0d expected %0d", c, obsSs[c], sqModel(tabA[si], tabB[si]));
            end
         end
         testsRun++;
         if (obsReady[c] !== expR) begin
            testsFailed++;
            $display("[TB] FAIL random_out_ready c=%0d got %b expected %b", c, obsReady[c], expR);
         end
         if (obsReady[c] === 1'b1) outCount++;
         if (expR) begin
            lastOut = magModel(tabA[oi], tabB[oi]);
            haveOut = 1'b1;
         end
         if (haveOut) begin
            testsRun++;
            if (obsOut[c] !== OUT_BITS'(lastOut)) begin
               testsFailed++;
               $display("[TB] FAIL random_data_out c=%0d got %0d expected %0d", c, obsOut[c], lastOut);
            end
         end
      end
      testsRun++;
      if (outCount != n) begin
         testsFailed++;
         $display("[TB] FAIL random_out_count got %0d expected %0d", outCount, n);
      end
   endtask

   task automatic test_gaps();
      int n;
      int total;
      logic haveOut;
      longint unsigned lastOut;
      logic pattern [5];
      pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      n = 30;
      total = n + LAT_OUT + 2;
      for (int i = 0; i < n; i++) begin
         tabRst[i]   = 1'b1;
         tabValid[i] = pattern[i % 5];
         tabA[i]     = IN_BITS'($urandom);
         tabB[i]     = IN_BITS'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      end
      applyStimulus(n, total);
      haveOut = 1'b0;
      lastOut = 0;
      for (int c = 0; c < total; c++) begin
         int oi;
         logic expR;
         oi = c - LAT_OUT;
         expR = ((oi >= 0) && (oi < n)) ? tabValid[oi] : 1'b0;
         testsRun++;
         if (obsReady[c] !== expR) begin
            testsFailed++;
            $display("[TB] FAIL gaps_out_ready c=%0d got %b expected %b", c, obsReady[c], expR);
         end
         if (expR) begin
            lastOut = magModel(tabA[oi], tabB[oi]);
            haveOut = 1'b1;
         end
         if (haveOut) begin
            testsRun++;
            if (obsOut[c] !== OUT_BITS'(lastOut)) begin
               testsFailed++;
               $display("[TB] FAIL gaps_data_out c=%0d got %0d expected %0d", c, obsOut[c], lastOut);
            end
         end
      end
   endtask

   task automatic test_reset_flush();
      for (int i = 0; i < 8; i++) begin
         tabRst[i]   = !((i == 5) || (i == 6));
         tabValid[i] = 1'b1;
         tabA[i]     = IN_BITS'($urandom);
         tabB[i]     = IN_BITS'($urandom);
      end
      tabA[7] = 16'd6;
      tabB[7] = 16'd8;
      applyStimulus(8, 30);
      for (int c = 6; c < 30; c++) begin
         testsRun++;
         if (obsReady[c] !== (c == 7 + LAT_OUT)) begin
            testsFailed++;
            $display("[TB] FAIL flush_out_ready c=%0d got %b expected %b", c, obsReady[c], (c == 7 + LAT_OUT));
         end
         testsRun++;
         if (obsSsReady[c] !== (c == 8)) begin
            testsFailed++;
            $display("[TB] FAIL flush_ss_ready c=%0d got %b expected %b", c, obsSsReady[c], (c == 8));
         end
         testsRun++;
         if (obsOut[c] !== ((c >= 7 + LAT_OUT) ? 17'd10 : 17'd0)) begin
            testsFailed++;
            $display("[TB] FAIL flush_data_out c=%0d got %0d", c, obsOut[c]);
         end
      end
      testsRun++;
      if (obsSs[8] !== 33'd100) begin
         testsFailed++;
         $display("[TB] FAIL flush_square_sum got %0d expected 100", obsSs[8]);
      end
   endtask

   initial begin
      rst           = 1'b0;
      data_in_ready = 1'b0;
      data_in_1     = '0;
      data_in_2     = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_random();
      test_gaps();
      test_reset_flush();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
